// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - IDLE/EXEC/DONE ALU execution unit with operand register file and result handshake
// Define ALU_EXEC_MUL_EN to enable the WIDTH-cycle shift-add multiply on op 111.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int RA = $clog2(NREGS),
  localparam int SA = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3+3*RA-1:0] cmd,
  input  logic              ld_en,
  input  logic [RA-1:0]     ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [3:0]        res_flags,
  output logic              res_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t           state, state_nx;
  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       op_q;
  logic [RA-1:0]    rd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cmd_op;
  logic [RA-1:0]    cmd_rd, cmd_ra, cmd_rb;
  logic             accept, exec_last;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_err, flag_c, flag_o;

  assign {cmd_op, cmd_rd, cmd_ra, cmd_rb} = cmd;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_EXEC_MUL_EN
  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_sum;
  logic [WIDTH-1:0]   mul_mplier;
  logic [SA-1:0]      mul_cnt;

  // mul_sum already includes the current step, so the last EXEC cycle sees the full product
  assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign exec_last = (op_q != OP_MUL) || (mul_cnt == SA'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (accept) begin
      mul_acc    <= '0;
      mul_mcand  <= {{WIDTH{1'b0}}, regs[cmd_ra]};
      mul_mplier <= regs[cmd_rb];
      mul_cnt    <= '0;
    end else if (state == EXEC) begin
      mul_acc    <= mul_sum;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + SA'(1);
    end
  end
`else
  assign exec_last = 1'b1;
`endif

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_err = 1'b0;
    flag_c  = 1'b0;
    flag_o  = 1'b0;
    case (op_q)
      OP_ADD: begin
        ext     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = ext[WIDTH-1:0];
        flag_c  = ext[WIDTH];
        flag_o  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ext     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = ext[WIDTH-1:0];
        flag_c  = ~ext[WIDTH];
        flag_o  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_res = a_q << b_q[SA-1:0];
      OP_MUL: begin
`ifdef ALU_EXEC_MUL_EN
        alu_res = mul_sum[WIDTH-1:0];
        flag_c  = |mul_sum[2*WIDTH-1:WIDTH];
`else
        alu_err = 1'b1;
`endif
      end
      default: alu_err = 1'b1;
    endcase
    alu_flags = alu_err ? 4'b0000 : {flag_o, flag_c, (alu_res == '0), alu_res[WIDTH-1]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = EXEC;
      EXEC:    if (exec_last) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (ld_en) regs[ld_addr] <= ld_data;
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        a_q  <= regs[cmd_ra];
        b_q  <= regs[cmd_rb];
      end
      // placed after the load so a same-edge writeback to the same register wins
      if (state == EXEC && exec_last) begin
        res_data  <= alu_res;
        res_flags <= alu_flags;
        res_err   <= alu_err;
        if (!alu_err) regs[rd_q] <= alu_res;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed bench with a cycle-level reference model of alu_exec_unit
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam int N = 8;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_MUL = 3'd7;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [11:0]  cmd = '0;
  logic         ld_en = 1'b0;
  logic [2:0]   ld_addr = '0;
  logic [W-1:0] ld_data = '0;
  logic         res_ready = 1'b0;
  logic         cmd_ready, res_valid, res_err, busy;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] mreg [N];
  bit           m_valid = 0, m_busy = 0, m_wb = 0;
  int           m_wait = 0;
  logic [W-1:0] m_data = '0, p_data = '0;
  logic [3:0]   m_flags = '0, p_flags = '0;
  logic         m_err = 1'b0, p_err = 1'b0;
  logic [2:0]   p_rd = '0;

  function automatic void model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic [3:0] f, output logic e);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s = 0;
    longint unsigned u = 0;
    logic [4:0] sh = b[4:0];
    bit o = 0, c = 0;
    e = 1'b0;
    r = '0;
    case (op)
      OP_ADD: begin u = longint'(a) + longint'(b); r = W'(u); c = (u >> W) != 0;
                    s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB: begin r = a - b; c = (a >= b);
                    s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLT: r = (sa < sb) ? 1 : 0;
      OP_SLL: r = a << sh;
      default: begin
        if (MUL_ON) begin u = longint'(a) * longint'(b); r = W'(u); c = (u >> W) != 0; end
        else e = 1'b1;
      end
    endcase
    f = e ? 4'b0000 : {o, c, (r == 0), r[W-1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mreg[i] = '0;
    m_valid = 0; m_busy = 0; m_wait = 0;
    m_data = '0; m_flags = '0; m_err = 1'b0;
  endtask

  // predicts what the next rising edge does with the inputs now on the pins
  task automatic model_step();
    m_wb = 0;
    if (m_valid) begin
      if (res_ready) begin m_valid = 0; m_busy = 0; end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1; m_data = p_data; m_flags = p_flags; m_err = p_err;
        m_wb = !p_err;
      end
    end else if (cmd_valid) begin
      model_op(cmd[11:9], mreg[cmd[5:3]], mreg[cmd[2:0]], p_data, p_flags, p_err);
      p_rd   = cmd[8:6];
      m_wait = (cmd[11:9] == OP_MUL && MUL_ON) ? W : 1;
      m_busy = 1;
    end
    if (ld_en) mreg[ld_addr] = ld_data;
    if (m_wb) mreg[p_rd] = p_data;
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    chk("cyc_res_valid", 64'(res_valid), 64'(m_valid));
    chk("cyc_busy",      64'(busy),      64'(m_busy));
    chk("cyc_cmd_ready", 64'(cmd_ready), 64'(!m_busy));
    chk("cyc_res_data",  64'(res_data),  64'(m_data));
    chk("cyc_res_flags", 64'(res_flags), 64'(m_flags));
    chk("cyc_res_err",   64'(res_err),   64'(m_err));
    if (!rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic load(input logic [2:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #2 ld_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    cmd_valid = 1'b1; cmd = {op, rd, ra, rb};
    @(posedge clk); #2 cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin lat = i; break; end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid: res_valid never rose within 200 cycles, required 1");
    end
  endtask

  task automatic release_res();
    @(posedge clk); #2 res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                     output int lat);
    issue(op, rd, ra, rb);
    wait_valid(lat);
  endtask

  task automatic issue_ld(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] la, input logic [W-1:0] ld);
    int lat;
    issue(op, rd, ra, rb);
    ld_en = 1'b1; ld_addr = la; ld_data = ld;
    @(posedge clk); #2 ld_en = 1'b0;
    wait_valid(lat);
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [W-1:0] exp, input string nm);
    int lat;
    run(OP_OR, r, r, r, lat);
    chk(nm, 64'(res_data), 64'(exp));
    release_res();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_reset_busy",      64'(busy),      64'd0);
    chk("post_reset_res_data",  64'(res_data),  64'd0);

    load(3'd1, 32'd5); load(3'd2, 32'd3);
    run(OP_ADD, 3'd0, 3'd1, 3'd2, lat);
    chk("add_latency", 64'(lat), 64'd2);
    chk("add_data", 64'(res_data), 64'd8);
    chk("add_flags", 64'(res_flags), 64'h0);
    release_res();
    read_reg(3'd0, 32'd8, "r0_after_add");

    load(3'd1, 32'h7FFF_FFFF); load(3'd2, 32'd1);
    run(OP_ADD, 3'd3, 3'd1, 3'd2, lat);
    chk("ovf_data", 64'(res_data), 64'h8000_0000);
    chk("ovf_flags", 64'(res_flags), 64'b1001);
    release_res();
    run(OP_SUB, 3'd4, 3'd2, 3'd2, lat);
    chk("sub_zero_data", 64'(res_data), 64'h0);
    chk("sub_zero_flags", 64'(res_flags), 64'b0110);
    release_res();

    load(3'd5, 32'd0); load(3'd6, 32'd1);
    run(OP_SUB, 3'd7, 3'd5, 3'd6, lat);
    chk("sub_wrap_data", 64'(res_data), 64'hFFFF_FFFF);
    chk("sub_wrap_flags", 64'(res_flags), 64'b0001);
    release_res();

    run(OP_SLT, 3'd3, 3'd7, 3'd5, lat);
    chk("slt_signed", 64'(res_data), 64'd1);
    release_res();
    load(3'd4, 32'h24);
    run(OP_SLL, 3'd3, 3'd6, 3'd4, lat);
    chk("sll_data", 64'(res_data), 64'h10);
    release_res();

    run(OP_AND, 3'd7, 3'd1, 3'd1, lat);
    @(posedge clk); #2 cmd_valid = 1'b1; cmd = {OP_XOR, 3'd2, 3'd1, 3'd6};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", 64'(res_data), 64'h7FFF_FFFF);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk); #2 res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;
    chk("release_res_valid", 64'(res_valid), 64'd0);
    chk("release_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #2 cmd_valid = 1'b0;
    wait_valid(lat);
    chk("xor_after_hold", 64'(res_data), 64'h7FFF_FFFE);
    release_res();

    load(3'd4, 32'h50); load(3'd5, 32'h05);
    issue_ld(OP_OR, 3'd3, 3'd4, 3'd5, 3'd3, 32'hAA);
    chk("collide_res", 64'(res_data), 64'h55);
    release_res();
    read_reg(3'd3, 32'h55, "collide_wb_wins");

    issue_ld(OP_ADD, 3'd6, 3'd4, 3'd4, 3'd4, 32'h999);
    chk("latched_operands", 64'(res_data), 64'hA0);
    release_res();
    read_reg(3'd4, 32'h999, "late_load_kept");
    run(OP_ADD, 3'd5, 3'd5, 3'd5, lat);
    chk("rd_eq_ra", 64'(res_data), 64'hA);
    release_res();
    read_reg(3'd5, 32'hA, "rd_eq_ra_reg");

`ifdef ALU_EXEC_MUL_EN
    load(3'd6, 32'd7); load(3'd7, 32'd6);
    run(OP_MUL, 3'd1, 3'd6, 3'd7, lat);
    chk("mul_latency", 64'(lat), 64'(W + 1));
    chk("mul_data", 64'(res_data), 64'd42);
    chk("mul_flags", 64'(res_flags), 64'b0000);
    release_res();
    load(3'd6, 32'hFFFF_FFFF); load(3'd7, 32'd2);
    run(OP_MUL, 3'd2, 3'd6, 3'd7, lat);
    chk("mul_carry_data", 64'(res_data), 64'hFFFF_FFFE);
    chk("mul_carry_flags", 64'(res_flags), 64'b0101);
    release_res();
    issue(OP_MUL, 3'd1, 3'd6, 3'd7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
`else
    run(OP_MUL, 3'd1, 3'd6, 3'd6, lat);
    chk("illegal_err", 64'(res_err), 64'd1);
    chk("illegal_data", 64'(res_data), 64'd0);
    chk("illegal_flags", 64'(res_flags), 64'd0);
    release_res();
    read_reg(3'd1, 32'h7FFF_FFFF, "illegal_rd_kept");
    issue(OP_ADD, 3'd1, 3'd4, 3'd4);
    rst = 1'b1;
`endif
    @(negedge clk);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_data", 64'(res_data), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    read_reg(3'd1, 32'd0, "abort_r1");
    read_reg(3'd4, 32'd0, "abort_r4");
    read_reg(3'd7, 32'd0, "abort_r7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
